// File: rtl/cpu_interlock_pkg.sv
// Shared op codes, FSM state encoding and helpers for the pipeline interlock.
package cpu_interlock_pkg;

  localparam int CNT_W = 8;

  localparam logic [6:0] OP_NOP    = 7'h00;
  localparam logic [6:0] OP_ADD_L  = 7'h01;
  localparam logic [6:0] OP_SUB_L  = 7'h02;
  localparam logic [6:0] OP_LOAD_L = 7'h10;
  localparam logic [6:0] OP_MUL_L  = 7'h20;
  localparam logic [6:0] OP_DIV_L  = 7'h21;
  localparam logic [6:0] OP_UDIV_L = 7'h22;
  localparam logic [6:0] OP_MOD_L  = 7'h23;
  localparam logic [6:0] OP_UMOD_L = 7'h24;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MC_STALL   = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  function automatic logic is_mul(input logic [6:0] op);
    return op == OP_MUL_L;
  endfunction

  function automatic logic is_div(input logic [6:0] op);
    return (op == OP_DIV_L) || (op == OP_UDIV_L) ||
           (op == OP_MOD_L) || (op == OP_UMOD_L);
  endfunction

endpackage

// File: rtl/cpu_interlock_counter.sv
// Multicycle occupancy down counter: load, decrement (saturating at zero), hold.
// Exists only in builds with CPU_INTERLOCK_MULTICYCLE_EN defined.
`ifdef CPU_INTERLOCK_MULTICYCLE_EN
import cpu_interlock_pkg::*;

module cpu_interlock_counter (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`endif

// File: rtl/cpu_interlock.sv
// Pipeline interlock: load-use, branch flush and multicycle execute stalls.
// Multicycle mul/div support is built only with CPU_INTERLOCK_MULTICYCLE_EN.
import cpu_interlock_pkg::*;

module cpu_interlock #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] dx_op_i,
  input  logic       dx_load_i,
  input  logic [3:0] dx_load_reg_i,
  input  logic       fd_valid_i,
  input  logic [3:0] fd_riA_i,
  input  logic [3:0] fd_riB_i,
  input  logic       branch_flag_i,
  input  logic       mem_busy_i,
  output logic       stall_fetch_o,
  output logic       stall_decode_o,
  output logic       stall_execute_o,
  output logic       flush_decode_o,
  output logic       bubble_o,
  output logic       busy_o
);

  state_e state_q;
  logic   load_use;
  logic   mc_op;
  logic   cnt_zero;

  assign load_use = fd_valid_i && dx_load_i &&
                    ((dx_load_reg_i == fd_riA_i) || (dx_load_reg_i == fd_riB_i));

`ifdef CPU_INTERLOCK_MULTICYCLE_EN
  // The entry cycle in RUN counts as one, the zero-count release cycle as another.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] mc_cnt;

  assign mc_op        = is_mul(dx_op_i) || is_div(dx_op_i);
  assign cnt_load_val = is_mul(dx_op_i) ? MUL_LOAD : DIV_LOAD;
  assign cnt_load     = (state_q == RUN) && !mem_busy_i && !branch_flag_i && mc_op;
  assign cnt_dec      = (state_q == MC_STALL) && !mem_busy_i && (mc_cnt != '0);

  cpu_interlock_counter u_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (mc_cnt),
    .zero     (cnt_zero)
  );
`else
  localparam int unused_cycles_cfg = MUL_CYCLES + DIV_CYCLES;
  logic unused_op;

  assign unused_op = ^dx_op_i;
  assign mc_op     = 1'b0;
  assign cnt_zero  = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else if (!mem_busy_i) begin
      case (state_q)
        RUN: begin
          if (branch_flag_i)  state_q <= FLUSH;
          else if (mc_op)     state_q <= MC_STALL;
          else if (load_use)  state_q <= LOAD_STALL;
          else                state_q <= RUN;
        end
        LOAD_STALL: state_q <= RUN;
        MC_STALL:   state_q <= cnt_zero ? RUN : MC_STALL;
        FLUSH:      state_q <= RUN;
        default:    state_q <= RUN;
      endcase
    end
  end

  // Same-cycle control: the stage sees the stall in the cycle the hazard appears.
  always_comb begin
    stall_fetch_o   = 1'b0;
    stall_decode_o  = 1'b0;
    stall_execute_o = 1'b0;
    flush_decode_o  = 1'b0;
    bubble_o        = 1'b0;
    busy_o          = 1'b0;
    if (!rst_i) begin
      busy_o = (state_q != RUN);
      if (mem_busy_i) begin
        stall_fetch_o   = 1'b1;
        stall_decode_o  = 1'b1;
        stall_execute_o = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (branch_flag_i) begin
              flush_decode_o = 1'b1;
              bubble_o       = 1'b1;
            end else if (mc_op) begin
              stall_fetch_o   = 1'b1;
              stall_decode_o  = 1'b1;
              stall_execute_o = 1'b1;
            end else if (load_use) begin
              stall_fetch_o  = 1'b1;
              stall_decode_o = 1'b1;
              bubble_o       = 1'b1;
            end
          end
          MC_STALL: begin
            if (!cnt_zero) begin
              stall_fetch_o   = 1'b1;
              stall_decode_o  = 1'b1;
              stall_execute_o = 1'b1;
            end
          end
          FLUSH: begin
            flush_decode_o = 1'b1;
            bubble_o       = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_interlock.sv
// Table-driven, scoreboarded bench for cpu_interlock; multicycle cases follow CPU_INTERLOCK_MULTICYCLE_EN.
module tb_cpu_interlock;
  import cpu_interlock_pkg::*;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  // Output vector order: {stall_fetch, stall_decode, stall_execute, flush_decode, bubble, busy}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_IDLE_BUSY = 6'b000001;
  localparam logic [5:0] O_BR   = 6'b000110;
  localparam logic [5:0] O_FL   = 6'b000111;
  localparam logic [5:0] O_STALL_RUN  = 6'b111000;
  localparam logic [5:0] O_STALL_BUSY = 6'b111001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] dx_op;
  logic       dx_load;
  logic [3:0] dx_load_reg;
  logic       fd_valid;
  logic [3:0] fd_ria, fd_rib;
  logic       branch_flag, mem_busy;
  logic       stall_fetch, stall_decode, stall_execute, flush_decode, bubble, busy;

  cpu_interlock #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dx_op_i         (dx_op),
    .dx_load_i       (dx_load),
    .dx_load_reg_i   (dx_load_reg),
    .fd_valid_i      (fd_valid),
    .fd_riA_i        (fd_ria),
    .fd_riB_i        (fd_rib),
    .branch_flag_i   (branch_flag),
    .mem_busy_i      (mem_busy),
    .stall_fetch_o   (stall_fetch),
    .stall_decode_o  (stall_decode),
    .stall_execute_o (stall_execute),
    .flush_decode_o  (flush_decode),
    .bubble_o        (bubble),
    .busy_o          (busy)
  );

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       load;
    logic [3:0] lreg;
    logic       fdv;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       br;
    logic       mb;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic in_t mk(input logic r, input logic [6:0] op, input logic ld,
                             input logic [3:0] lreg, input logic fdv, input logic [3:0] ra,
                             input logic [3:0] rb, input logic br, input logic mb);
    in_t v;
    v.rst = r; v.op = op; v.load = ld; v.lreg = lreg; v.fdv = fdv;
    v.ra = ra; v.rb = rb; v.br = br; v.mb = mb;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(1'b0, OP_NOP, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endfunction

  function automatic void add(input in_t i, input logic [5:0] e, input string nm);
    vec_t v;
    v.in = i; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic drive(input in_t i);
    rst = i.rst; dx_op = i.op; dx_load = i.load; dx_load_reg = i.lreg;
    fd_valid = i.fdv; fd_ria = i.ra; fd_rib = i.rb;
    branch_flag = i.br; mem_busy = i.mb;
  endtask

  task automatic check_out();
    sb_t        e;
    logic [5:0] act;
    act = {stall_fetch, stall_decode, stall_execute, flush_decode, bubble, busy};
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %b, no expected entry", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.name, act, e.exp);
      end
    end
  endtask

  // Drive after the rising edge, compare on the falling edge.
  task automatic step(input in_t i, input logic [5:0] e, input string nm);
    sb_t s;
    drive(i);
    s.exp = e; s.name = nm;
    sbq.push_back(s);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

`ifdef CPU_INTERLOCK_MULTICYCLE_EN
  task automatic div_seq(input logic [6:0] op, input int hold_at, input int hold_len,
                         input string nm);
    in_t run_op, held;
    int  cnt;
    run_op = idle(); run_op.op = op;
    held = run_op; held.mb = 1'b1;
    step(run_op, O_STALL_RUN, {nm, "_entry"});
    cnt = DIVC - 2;
    while (cnt > 0) begin
      if (cnt == hold_at) begin
        for (int h = 0; h < hold_len; h++) step(held, O_STALL_BUSY, {nm, "_memhold"});
      end
      step(run_op, O_STALL_BUSY, {nm, "_stall"});
      cnt--;
    end
    step(run_op, O_IDLE_BUSY, {nm, "_release"});
    step(idle(), O_NONE, {nm, "_run"});
  endtask
`endif

  initial begin
    drive(mk(1'b1, OP_NOP, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;

    add(mk(1, OP_NOP, 0, 0, 0, 0, 0, 1, 1), O_NONE, "reset_gates_outputs");
    add(mk(1, OP_NOP, 1, 3, 1, 3, 3, 0, 0), O_NONE, "reset_gates_loaduse");
    add(idle(), O_NONE, "idle_after_reset");
    add(mk(0, OP_NOP, 1, 3, 1, 5, 3, 0, 0), O_LU, "loaduse_rib");
    add(idle(), O_IDLE_BUSY, "load_stall_cycle");
    add(idle(), O_NONE, "back_to_run");
    add(mk(0, OP_NOP, 1, 7, 0, 7, 0, 0, 0), O_NONE, "no_loaduse_fd_invalid");
    add(mk(0, OP_NOP, 1, 2, 1, 4, 5, 0, 0), O_NONE, "no_loaduse_reg_mismatch");
    add(mk(0, OP_ADD_L, 0, 7, 1, 7, 7, 0, 0), O_NONE, "no_loaduse_not_load");
    add(mk(0, OP_NOP, 1, 7, 1, 7, 1, 0, 0), O_LU, "loaduse_ria");
    add(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1), O_STALL_BUSY, "membusy_in_load_stall");
    add(mk(0, OP_NOP, 1, 7, 1, 7, 1, 0, 0), O_IDLE_BUSY, "load_stall_ignores_hazard");
    add(idle(), O_NONE, "run_after_load_stall");
    add(mk(0, OP_NOP, 0, 0, 0, 0, 0, 1, 0), O_BR, "branch_cycle1");
    add(mk(0, OP_NOP, 0, 0, 0, 0, 0, 1, 0), O_FL, "flush_cycle2_ignores_branch");
    add(idle(), O_NONE, "flush_done");
    add(mk(0, OP_NOP, 1, 6, 1, 6, 0, 1, 0), O_BR, "branch_beats_loaduse");
    add(mk(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1), O_STALL_BUSY, "membusy_in_flush");
    add(idle(), O_FL, "flush_resumes");
    add(idle(), O_NONE, "run_after_frozen_flush");
    add(mk(0, OP_NOP, 1, 6, 1, 6, 0, 1, 1), O_STALL_RUN, "membusy_beats_branch");
    add(idle(), O_NONE, "branch_not_taken_while_busy");
    add(mk(0, OP_NOP, 0, 0, 0, 0, 0, 1, 0), O_BR, "branch_before_reset");
    add(mk(1, OP_NOP, 0, 0, 0, 0, 0, 0, 0), O_NONE, "reset_mid_flush");
    add(idle(), O_NONE, "run_after_reset_flush");
`ifdef CPU_INTERLOCK_MULTICYCLE_EN
    add(mk(0, OP_MUL_L, 1, 4, 1, 4, 0, 0, 0), O_STALL_RUN, "mul_beats_loaduse");
    for (int c = 0; c < MULC - 2; c++) add(mk(0, OP_MUL_L, 1, 4, 1, 4, 0, 0, 0),
                                           O_STALL_BUSY, "mul_stall");
    add(mk(0, OP_MUL_L, 1, 4, 1, 4, 0, 1, 0), O_IDLE_BUSY, "mul_release_ignores_branch");
    add(mk(0, OP_NOP, 1, 4, 1, 4, 0, 0, 0), O_LU, "loaduse_reevaluated");
    add(idle(), O_IDLE_BUSY, "load_stall_after_mul");
    add(idle(), O_NONE, "run_after_mul");
`else
    add(mk(0, OP_MUL_L, 0, 0, 1, 1, 2, 0, 0), O_NONE, "mul_single_cycle");
    add(mk(0, OP_DIV_L, 0, 0, 1, 1, 2, 0, 0), O_NONE, "div_single_cycle");
    add(mk(0, OP_MUL_L, 1, 4, 1, 4, 0, 0, 0), O_LU, "mul_loaduse_plain");
    add(idle(), O_IDLE_BUSY, "load_stall_after_mul");
    add(idle(), O_NONE, "run_after_mul");
`endif

    for (int k = 0; k < tbl.size(); k++) step(tbl[k].in, tbl[k].exp, tbl[k].name);

`ifdef CPU_INTERLOCK_MULTICYCLE_EN
    div_seq(OP_DIV_L, -1, 0, "div");
    div_seq(OP_UDIV_L, -1, 0, "udiv");
    div_seq(OP_MOD_L, -1, 0, "mod");
    div_seq(OP_UMOD_L, -1, 0, "umod");
    div_seq(OP_DIV_L, 10, 5, "div_memhold");
    begin
      in_t d;
      d = idle(); d.op = OP_DIV_L;
      step(d, O_STALL_RUN, "rstmc_entry");
      for (int c = 0; c < 5; c++) step(d, O_STALL_BUSY, "rstmc_stall");
      d.rst = 1'b1;
      step(d, O_NONE, "rstmc_reset");
      step(idle(), O_NONE, "rstmc_run");
    end
`endif

    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
